// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: two result ports feed an in-order queue that is
// drained through a SETUP/STROBE write sequence giving a clean one-cycle write_en.
module regfile_writeback #(
   parameter int BitWidth = 32,
   parameter int NumReg = 32,
   parameter int Depth = 4,
   localparam int RegSelWidth = $clog2(NumReg)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in0_valid,
   output logic                   in0_ready,
   input  logic [RegSelWidth-1:0] in0_dest,
   input  logic [BitWidth-1:0]    in0_data,
   input  logic                   in1_valid,
   output logic                   in1_ready,
   input  logic [RegSelWidth-1:0] in1_dest,
   input  logic [BitWidth-1:0]    in1_data,
   output logic [BitWidth-1:0]    write_data,
   output logic [RegSelWidth-1:0] write_dest,
   output logic                   write_en,
   output logic [NumReg-1:0]      pending_mask,
   output logic                   busy
);

   localparam int PtrWidth = $clog2(Depth);
   localparam int CntWidth = PtrWidth + 1;
   localparam logic [NumReg-1:0] OneHotZero = NumReg'(1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE
   } state_e;

   state_e                 state_q, state_d;
   logic [CntWidth-1:0]    count_q, count_d;
   logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0]    rd_ptr_q, rd_ptr_d;
   logic [RegSelWidth-1:0] dest_q [Depth];
   logic [RegSelWidth-1:0] dest_d [Depth];
   logic [BitWidth-1:0]    data_q [Depth];
   logic [BitWidth-1:0]    data_d [Depth];
   logic [RegSelWidth-1:0] write_dest_q, write_dest_d;
   logic [BitWidth-1:0]    write_data_q, write_data_d;
   logic                   write_en_q, write_en_d;

   logic [CntWidth-1:0]    free;
   logic                   in0_push;
   logic                   in1_push;
   logic                   pop;
   logic [PtrWidth-1:0]    in1_slot;
   logic [PtrWidth-1:0]    offset;

   // Readiness only looks at occupancy; in1 yields its last free slot to in0.
   always_comb begin
      free      = CntWidth'(Depth) - count_q;
      in0_ready = rst && (free != '0);
      in0_push  = in0_valid && in0_ready && (in0_dest != '0);
      in1_ready = rst && ((free >= CntWidth'(2)) || ((free != '0) && !in0_push));
      in1_push  = in1_valid && in1_ready && (in1_dest != '0);
      pop       = (count_q != '0) && (state_q != SETUP);
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      dest_d       = dest_q;
      data_d       = data_q;
      write_dest_d = write_dest_q;
      write_data_d = write_data_q;
      write_en_d   = 1'b0;
      in1_slot     = wr_ptr_q + PtrWidth'(in0_push);

      if (in0_push) begin
         dest_d[wr_ptr_q] = in0_dest;
         data_d[wr_ptr_q] = in0_data;
      end
      if (in1_push) begin
         dest_d[in1_slot] = in1_dest;
         data_d[in1_slot] = in1_data;
      end
      wr_ptr_d = wr_ptr_q + PtrWidth'(in0_push) + PtrWidth'(in1_push);

      if (pop) begin
         write_dest_d = dest_q[rd_ptr_q];
         write_data_d = data_q[rd_ptr_q];
         rd_ptr_d     = rd_ptr_q + PtrWidth'(1);
      end
      count_d = count_q + CntWidth'(in0_push) + CntWidth'(in1_push) - CntWidth'(pop);

      case (state_q)
         IDLE:    state_d = pop ? SETUP : IDLE;
         SETUP: begin
            state_d    = STROBE;
            write_en_d = 1'b1;
         end
         STROBE:  state_d = pop ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A queue slot counts as live when its distance from the read pointer is below count.
   always_comb begin
      pending_mask = '0;
      offset       = '0;
      for (int i = 0; i < Depth; i++) begin
         offset = PtrWidth'(i) - rd_ptr_q;
         if ({1'b0, offset} < count_q) begin
            pending_mask = pending_mask | (OneHotZero << dest_q[i]);
         end
      end
      if (state_q != IDLE) begin
         pending_mask = pending_mask | (OneHotZero << write_dest_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         write_dest_q <= '0;
         write_data_q <= '0;
         write_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         write_dest_q <= write_dest_d;
         write_data_q <= write_data_d;
         write_en_q   <= write_en_d;
      end
   end

   // Payload storage needs no reset: occupancy is tracked by count and the pointers.
   always_ff @(posedge clk) begin
      dest_q <= dest_d;
      data_q <= data_d;
   end

   assign write_dest = write_dest_q;
   assign write_data = write_data_q;
   assign write_en   = write_en_q;
   assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL have parameter BitWidth, default 32, giving the data width of every write.
REQ-002 The block SHALL have parameter NumReg, default 32, giving the register count; RegSelWidth = $clog2(NumReg).
REQ-003 The block SHALL have parameter Depth, default 4, giving the queue entry count (power of two, >=2).
REQ-004 The block SHALL have clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have rst, input, 1 bit, reset; asynchronous and active-low.
REQ-006 The block SHALL have in0_valid/in0_ready/in0_dest/in0_data, in/out/in/in, 1/1/RegSelWidth/BitWidth bits: ALU result port, high priority.
REQ-007 The block SHALL have in1_valid/in1_ready/in1_dest/in1_data, same directions and widths: load result port, low priority.
REQ-008 The block SHALL have write_data, output, BitWidth bits, and write_dest, output, RegSelWidth bits: register file write bus.
REQ-009 The block SHALL have write_en, output, 1 bit: register file write strobe; the register file captures on its rising edge.
REQ-010 The block SHALL have pending_mask, output, NumReg bits: bit r set while any accepted, uncommitted write targets register r.
REQ-011 The block SHALL have busy, output, 1 bit: high while the queue is non-empty or state is not IDLE.

Function
REQ-012 A port transfer SHALL occur in a cycle where valid and ready are both high; valid SHALL NOT depend on ready.
REQ-013 A transfer with dest==0 SHALL be accepted and discarded: no queue slot, no write_en, no pending_mask effect.
REQ-014 in0_ready SHALL be high when free slots (Depth - count) >= 1.
REQ-015 in1_ready SHALL be high when free >= 2, or when free >= 1 and no nonzero-dest in0 transfer occurs that cycle.
REQ-016 Simultaneous transfers SHALL enqueue in0 ahead of in1; commit order SHALL equal enqueue order.
REQ-017 Write FSM states: IDLE, SETUP, STROBE.
REQ-018 IDLE: if queue non-empty, pop head into write_dest/write_data registers and go to SETUP; else stay.
REQ-019 SETUP: write_en=0, bus stable; next state STROBE with write_en registered high.
REQ-020 STROBE: write_en=1, bus unchanged; next edge write_en low, and pop next head to SETUP if non-empty, else IDLE.
REQ-021 write_en SHALL be a registered, glitch-free pulse exactly one cycle long; write_dest/write_data SHALL be stable from the SETUP cycle through the STROBE cycle.
REQ-022 Latency: transfer in cycle 0 with empty queue and IDLE SHALL give SETUP in cycle 2 and write_en high in cycle 3; sustained throughput SHALL be one write per 2 cycles.
REQ-023 Enqueue and pop in the same edge SHALL both take effect; count SHALL stay in 0..Depth; pointers SHALL wrap modulo Depth.
REQ-024 pending_mask SHALL be the OR of one-hot(dest) over valid queue entries plus the in-flight entry in SETUP/STROBE; it is combinational from state, set the cycle after transfer, clear the cycle after STROBE unless another entry holds the same dest.

Reset
REQ-025 While rst is low, queue SHALL be empty, state IDLE, and write_en=0, write_dest=0, write_data=0, pending_mask=0, busy=0, immediately and regardless of clk.
REQ-026 Reset mid-write SHALL drop write_en asynchronously with no further strobe; queued entries SHALL be discarded.
REQ-027 in0_ready and in1_ready SHALL be low while rst is low.

Verification
REQ-028 Single write: in0 dest=5 data=0xDEADBEEF in cycle 0 -> write_dest=5/write_data=0xDEADBEEF in cycle 2, write_en high only in cycle 3, pending_mask[5] high cycles 1-3.
REQ-029 Dual accept: in0 dest=1 data=0x11, in1 dest=2 data=0x22 same cycle, queue empty -> both ready; strobes to x1 then x2, 2 cycles apart.
REQ-030 Full queue: 4 writes enqueued with FSM stalled in SETUP -> in0_ready=0, in1_ready=0; in1 accepted when free=1 and in0_valid=0.
REQ-031 x0 drop: in0 dest=0 data=0xFFFFFFFF -> ready high, no write_en pulse, pending_mask stays 0.
REQ-032 Same-dest ordering: writes x7=0xA then x7=0xB -> strobes in that order; pending_mask[7] stays high until second strobe ends.
REQ-033 Reset mid-STROBE: rst low during write_en=1 -> write_en, busy, pending_mask zero within the same cycle; no strobe after release.
